conv_stream_ctrl: RTL and testbench

//  Sequencer for the 4-tap nibble convolution datapath (x[3:0] * h[3:0], 7 outputs y0..y6, packed 4b each into Result[27:0]).

---
 rtl/conv_stream_ctrl.sv | 159 +++++++++++++++
 tb/tb_conv_stream_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_ctrl.sv
// Stream sequencer for the 4-tap nibble convolution datapath: runs N input blocks, overlap-adds tails, emits a flush word.
// Optional build macro CONV_SAT_EN: overlap-add sums saturate at 4'hF instead of wrapping mod 16.
module conv_stream_ctrl #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [15:0]      cmd_kernel,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [31:0]      conv_a,
    output logic [31:0]      conv_b,
    input  logic [31:0]      conv_result,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [15:0]      kernel_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] blk_cnt;
    logic [11:0]      tail_q;      // {t6, t5, t4}
    logic [15:0]      out_q;
    logic             out_v;
    logic             done_q;

    logic             slot_free;
    logic             load_cmd;
    logic             accept;
    logic             load_flush;
    logic             pulse_done;
    logic [15:0]      acc_word;
    logic             unused_result;

    function automatic logic [3:0] ovl_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef CONV_SAT_EN
        return s[4] ? 4'hF : s[3:0];
`else
        return s[3:0];
`endif
    endfunction

    assign slot_free     = !out_v || out_ready;
    assign conv_a        = {16'h0000, in_data};
    assign conv_b        = {16'h0000, kernel_q};
    assign unused_result = ^conv_result[31:28];

    always_comb begin
        acc_word = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            acc_word[4*i +: 4] = ovl_add(conv_result[4*i +: 4], tail_q[4*i +: 4]);
        end
        acc_word[15:12] = conv_result[15:12];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        load_cmd   = 1'b0;
        accept     = 1'b0;
        load_flush = 1'b0;
        pulse_done = 1'b0;
        cmd_ready  = (state == S_IDLE);
        in_ready   = (state == S_RUN) && slot_free;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    load_cmd = 1'b1;
                    state_n  = (cmd_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (in_valid && slot_free) begin
                    accept = 1'b1;
                    if (blk_cnt == len_q - LEN_W'(1)) begin
                        state_n = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (slot_free) begin
                    load_flush = 1'b1;
                    state_n    = S_DONE;
                end
            end
            S_DONE: begin
                // An empty slot here means a zero-length command, whose done was raised on accept.
                if (!out_v) begin
                    state_n = S_IDLE;
                end else if (out_ready) begin
                    pulse_done = 1'b1;
                    state_n    = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kernel_q <= '0;
            len_q    <= '0;
            blk_cnt  <= '0;
            tail_q   <= '0;
            out_q    <= '0;
            out_v    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= pulse_done || (load_cmd && (cmd_len == '0));
            if (load_cmd) begin
                kernel_q <= cmd_kernel;
                len_q    <= cmd_len;
                blk_cnt  <= '0;
                tail_q   <= '0;
            end
            if (accept) begin
                out_q   <= acc_word;
                out_v   <= 1'b1;
                tail_q  <= conv_result[27:16];
                blk_cnt <= blk_cnt + LEN_W'(1);
            end else if (load_flush) begin
                out_q <= {4'h0, tail_q};
                out_v <= 1'b1;
            end else if (out_v && out_ready) begin
                out_v <= 1'b0;
            end
        end
    end

    assign out_valid = out_v;
    assign out_data  = out_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Self-checking bench for conv_stream_ctrl: directed cases plus random commands against a full linear-convolution model.
module tb_conv_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_kernel = '0;
    logic [7:0]  cmd_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [31:0] conv_a;
    logic [31:0] conv_b;
    logic [31:0] conv_result;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    conv_stream_ctrl #(.LEN_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kernel(cmd_kernel), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .conv_a(conv_a), .conv_b(conv_b), .conv_result(conv_result),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] nib(input logic [15:0] w, input int i);
        logic [15:0] t;
        t = w >> (4 * i);
        return t[3:0];
    endfunction

    // Combinational convolution unit the controller drives: 7 truncated partial sums.
    function automatic logic [31:0] datapath(input logic [15:0] x, input logic [15:0] h);
        logic [31:0] r;
        int s;
        r = '0;
        for (int k = 0; k < 7; k++) begin
            s = 0;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    if (i + j == k) s += int'(nib(x, i)) * int'(nib(h, j));
            r = r | (32'(s % 16) << (4 * k));
        end
        return r;
    endfunction

    assign conv_result = datapath(conv_a[15:0], conv_b[15:0]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [15:0] xs [0:255];
    logic [15:0] model_q [$];
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];

    // Expected output words of one command.
    task automatic model_build(input logic [15:0] h, input int n);
        model_q.delete();
        if (n == 0) return;
`ifdef CONV_SAT_EN
        begin
            logic [11:0] tail;
            logic [31:0] y;
            logic [15:0] w;
            int s;
            tail = '0;
            for (int b = 0; b < n; b++) begin
                y = datapath(xs[b], h);
                w = '0;
                for (int i = 0; i < 3; i++) begin
                    s = int'(y[4*i +: 4]) + int'(tail[4*i +: 4]);
                    if (s > 15) s = 15;
                    w = w | (16'(s) << (4 * i));
                end
                w[15:12] = y[15:12];
                model_q.push_back(w);
                tail = y[27:16];
            end
            model_q.push_back({4'h0, tail});
        end
`else
        begin
            logic [15:0] w;
            int s, q;
            w = '0;
            for (int p = 0; p < 4 * n + 3; p++) begin
                s = 0;
                for (int j = 0; j < 4; j++) begin
                    q = p - j;
                    if (q >= 0 && q < 4 * n) s += int'(nib(xs[q / 4], q % 4)) * int'(nib(h, j));
                end
                w = w | (16'(s % 16) << (4 * (p % 4)));
                if (p % 4 == 3 || p == 4 * n + 2) begin
                    model_q.push_back(w);
                    w = '0;
                end
            end
        end
`endif
    endtask

    int cyc = 0;
    int acc_cyc = 0;
    int last_hs = 0;
    int cur_len = 0;
    int done_cnt = 0;
    bit prev_acc = 0;
    bit stall_prev = 0;
    logic [15:0] stall_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            prev_acc   = 0;
            stall_prev = 0;
        end else begin
            if (prev_acc) chk("latency", 32'(out_valid), 32'd1);
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(stall_data));
            end
            if (out_valid && !out_ready) chk("backpressure", 32'(in_ready), 32'd0);
            if (in_valid && in_ready) chk("conv_a", conv_a, {16'h0, in_data});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("word", 32'(out_data), 32'(exp_q.pop_front()));
                end
                got_q.push_back(out_data);
                last_hs = cyc;
            end
            if (done) begin
                chk("done_words_left", 32'(exp_q.size()), 32'd0);
                chk("done_timing", 32'(cyc), 32'((cur_len == 0) ? acc_cyc + 1 : last_hs + 1));
                done_cnt++;
            end
            if (cmd_valid && cmd_ready) begin
                acc_cyc = cyc;
                cur_len = int'(cmd_len);
            end
            prev_acc   = in_valid && in_ready;
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    int ready_mode = 0;
    int stall_left = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: out_ready = 1'b0;
                default: begin
                    if (out_valid && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Called at posedge+1 with the DUT idle.
    task automatic issue_cmd(input logic [15:0] h, input int n);
        int g;
        cmd_valid  = 1'b1;
        cmd_kernel = h;
        cmd_len    = 8'(n);
        g = 0;
        @(negedge clk);
        while (!cmd_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk("cmd_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [15:0] h, input int n, input bit rnd_valid);
        int d0, g, b;
        bit acc;
        model_build(h, n);
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        got_q.delete();
        d0 = done_cnt;
        issue_cmd(h, n);
        b = 0;
        g = 0;
        while (b < n && g < 2000) begin
            in_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = xs[b];
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) b++;
            g++;
        end
        in_valid = 1'b0;
        if (g >= 2000) chk("input_timeout", 32'(b), 32'(n));
        g = 0;
        while (done_cnt == d0 && g < 500) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
        chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("words_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_lit(input string name, input int cnt, input logic [15:0] w0,
                           input logic [15:0] w1, input logic [15:0] w2);
        logic [15:0] lit [3];
        lit[0] = w0;
        lit[1] = w1;
        lit[2] = w2;
        chk({name, "_count"}, 32'(got_q.size()), 32'(cnt));
        chk({name, "_model_count"}, 32'(model_q.size()), 32'(cnt));
        for (int i = 0; i < cnt; i++) begin
            if (i < got_q.size()) chk({name, "_dut"}, 32'(got_q[i]), 32'(lit[i]));
            if (i < model_q.size()) chk({name, "_model"}, 32'(model_q[i]), 32'(lit[i]));
        end
    endtask

    initial begin
        int d0, g;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_conv_b", conv_b, 32'd0);

        xs[0] = 16'h1111;
        run_cmd(16'h1111, 1, 1'b0);
        chk_lit("t1", 2, 16'h4321, 16'h0123, 16'h0000);

        xs[0] = 16'h1111;
        xs[1] = 16'h1111;
        run_cmd(16'h1111, 2, 1'b0);
        chk_lit("t2", 3, 16'h4321, 16'h4444, 16'h0123);

        run_cmd(16'hABCD, 0, 1'b0);
        chk_lit("t3", 0, 16'h0000, 16'h0000, 16'h0000);

        ready_mode = 3;
        stall_left = 5;
        for (int i = 0; i < 3; i++) xs[i] = 16'(i * 16'h1357 + 16'h0246);
        run_cmd(16'h2143, 3, 1'b0);
        chk("t4_count", 32'(got_q.size()), 32'd4);
        chk("t4_stall_used", 32'(stall_left), 32'd0);
        ready_mode = 0;

        xs[0] = 16'h3333;
        xs[1] = 16'h3333;
        run_cmd(16'h3333, 2, 1'b0);
`ifdef CONV_SAT_EN
        chk_lit("t5", 3, 16'h4B29, 16'h4F4F, 16'h092B);
`else
        chk_lit("t5", 3, 16'h4B29, 16'h4444, 16'h092B);
`endif

        // Abort mid-command with a word held in the output slot.
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        d0 = done_cnt;
        issue_cmd(16'h1111, 3);
        in_valid = 1'b1;
        in_data  = 16'h1111;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_pending", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
        xs[0] = 16'h1111;
        run_cmd(16'h1111, 1, 1'b0);
        chk_lit("t6_clean", 2, 16'h4321, 16'h0123, 16'h0000);

        for (int c = 0; c < 25; c++) begin
            int n;
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) xs[i] = 16'($urandom);
            ready_mode = $urandom_range(0, 1);
            run_cmd(16'($urandom), n, 1'b1);
        end
        ready_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
